shift_divider: RTL and testbench
================================

Name: shift_divider

Overview:
- Sequential restoring divider for the FPGA arithmetic lab datapath; counterpart to the add-shift multiplier.
- Registers shift left: the remainder/quotient pair {A,Q} moves toward the MSB, opposite to the multiplier's right shift.
- Takes switch-level operands on a Run pulse, iterates one quotient bit per clock, and holds Quotient/Remainder for the hex displays until Run is released.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
- Clk  input  1  system clock, all state updates on posedge.
- Reset  input  1  synchronous, active-high; clock Clk.
- Run  input  1  start request, level-sensitive, sampled in IDLE only.
- Dividend  input  WIDTH  numerator, captured on start.
- Divisor  input  WIDTH  denominator, captured on start.
- Busy  output  1  high while the state is CALC (or FIX).
- Done  output  1  high in DONE; results valid.
- Div_By_Zero  output  1  high in DONE when captured Divisor == 0.
- Quotient  output  WIDTH  Q register.
- Remainder  output  WIDTH  A register.

Behaviour:
- Reset: state IDLE; A, Q, M, count cleared; Busy=0, Done=0, Div_By_Zero=0, Quotient=0, Remainder=0. Reset wins over every other event, including mid-CALC; a partial result is discarded.
- States: IDLE, CALC, FIX (only under SIGNED_DIV_EN), DONE.
- IDLE, Run=1 at edge E0:
  - Divisor != 0: A<=0, Q<=Dividend, M<=Divisor, count<=0, next state CALC.
  - Divisor == 0: Q<=all ones, A<=Dividend, Div_By_Zero<=1, next state DONE. Done is visible after 1 edge.
- IDLE, Run=0: hold all registers. Results from the previous operation stay on the outputs.
- CALC, one iteration per edge:
  - Shift {A,Q} left by 1.
  - Compute trial = {1'b0,A_shifted} - {1'b0,M} at WIDTH+1 bits.
  - If trial MSB = 0 (no borrow): A<=trial[WIDTH-1:0], Q[0]<=1. Otherwise A keeps the shifted value and Q[0]<=0.
  - A_shifted takes WIDTH+1 bits internally (carry out of A retained) so divisors with MSB set are handled.
  - count increments. When count == WIDTH-1, next state is DONE (or FIX).
- Latency: Done rises WIDTH edges after E0 (8 for the default). Add 1 edge under SIGNED_DIV_EN.
- DONE: Done=1 and Busy=0. Stays in DONE while Run=1. Goes to IDLE on the first edge with Run=0, and Done and Div_By_Zero clear there. Holding Run high never restarts a division.
- Run toggling during CALC/FIX is ignored.
- Operands changing after E0 have no effect on the result.
- Boundaries:
  - Dividend < Divisor gives Q=0, R=Dividend.
  - Divisor=1 gives Q=Dividend, R=0.
  - Dividend=0 gives Q=0, R=0 with full latency.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement. At E0, magnitudes are loaded and the signs of Dividend and Divisor are registered.
  - CALC runs unsigned on the magnitudes.
  - FIX state, one edge: Quotient is negated if the signs differ; Remainder is negated if Dividend was negative. Division truncates toward zero.
  - Most-negative / -1 yields Quotient = most-negative (wraps), R=0.
  - Divide-by-zero behaviour is unchanged (raw Dividend returned in R).
- Undefined: unsigned only, no FIX state, no sign registers.

Decomposition:
- Package div_pkg: state enum type (IDLE, CALC, FIX, DONE) and DIV_WIDTH_DEFAULT=8.
- One natural sub-module: shl_reg, a WIDTH-bit left shift register with synchronous Reset, Load, Shift_En, serial Shift_In at LSB, and Shift_Out = MSB.
  - Instantiate twice (A and Q), chained Q.Shift_Out -> A.Shift_In.
  - The borrow/no-borrow writeback of A and Q[0] uses Load with the computed value.

Test Plan:
- 100/7, Run pulse -> Done after exactly 8 edges; Quotient=14 (0x0E), Remainder=2, Div_By_Zero=0, Busy high for cycles 1-8.
- 255/1, then 3/200, then 200/128 -> Q=255 R=0; Q=0 R=3; Q=1 R=72; each completes in 8 edges.
- 5/0 -> Done after 1 edge, Quotient=0xFF, Remainder=5, Div_By_Zero=1. Dropping Run -> IDLE, Done=0, Div_By_Zero=0.
- Run held high for 30 cycles on 50/6 -> single division, Q=8 R=2, Done stays 1, no second Busy period. Release Run -> IDLE, Q/R still 8/2.
- Reset asserted at CALC cycle 4 of 100/7 -> next edge IDLE, all outputs 0. New Run with 9/4 -> Q=2 R=1.
- SIGNED_DIV_EN: -100/7 -> Done after 9 edges, Q=0xF2 (-14), R=0xFE (-2). Then 100/-7 -> Q=0xF2 R=2. Then -128/-1 -> Q=0x80 R=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the shift-left restoring divider.
// The FIX state is only reachable when the design is built with SIGNED_DIV_EN.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/shift_divider_shl_reg.sv
// WIDTH-bit left shift register: serial input enters at the LSB, the MSB is exposed as Shift_Out.
// Load has priority over Shift_En so a computed value can overwrite a pending shift.
module shl_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic [WIDTH-1:0] Load_Val,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Shift_Out
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk) begin
    if (Reset)         data_q <= '0;
    else if (Load)     data_q <= Load_Val;
    else if (Shift_En) data_q <= {data_q[WIDTH-2:0], Shift_In};
  end

  assign Data_Out  = data_q;
  assign Shift_Out = data_q[WIDTH-1];

endmodule

// File: rtl/shift_divider.sv
// Sequential restoring divider: {A,Q} shifts left one quotient bit per clock.
// Build with SIGNED_DIV_EN for two's-complement operands (adds a one-cycle FIX state).
module shift_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    count_q;
  logic             busy_q, done_q, dbz_q;

  logic             a_load, a_shift, q_load, q_shift;
  logic [WIDTH-1:0] a_d, q_d;
  logic             a_msb, q_msb;
  logic [WIDTH:0]   a_shifted, trial;
  logic             last_iter;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

`ifdef SIGNED_DIV_EN
  logic q_neg_q, r_neg_q;
  assign dividend_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign divisor_mag  = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
`else
  assign dividend_mag = Dividend;
  assign divisor_mag  = Divisor;
`endif

  // The bit shifted out of A is kept so divisors with their MSB set still compare correctly.
  assign a_shifted = {a_msb, Remainder[WIDTH-2:0], q_msb};
  assign trial     = a_shifted - {1'b0, m_q};
  assign last_iter = (count_q == CW'(WIDTH - 1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    a_load  = 1'b0;
    a_shift = 1'b0;
    q_load  = 1'b0;
    q_shift = 1'b0;
    a_d     = '0;
    q_d     = '0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          a_load = 1'b1;
          q_load = 1'b1;
          if (Divisor == '0) begin
            a_d = Dividend;
            q_d = '1;
          end else begin
            a_d = '0;
            q_d = dividend_mag;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          a_load = 1'b1;
          a_d    = trial[WIDTH-1:0];
          q_load = 1'b1;
          q_d    = {Quotient[WIDTH-2:0], 1'b1};
        end else begin
          a_shift = 1'b1;
          q_shift = 1'b1;
        end
      end
`ifdef SIGNED_DIV_EN
      FIX: begin
        a_load = 1'b1;
        q_load = 1'b1;
        a_d    = r_neg_q ? -Remainder : Remainder;
        q_d    = q_neg_q ? -Quotient  : Quotient;
      end
`endif
      default: ;
    endcase
  end

  shl_reg #(.WIDTH(WIDTH)) u_q_reg (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (q_load),
    .Shift_En (q_shift),
    .Shift_In (1'b0),
    .Load_Val (q_d),
    .Data_Out (Quotient),
    .Shift_Out(q_msb)
  );

  shl_reg #(.WIDTH(WIDTH)) u_a_reg (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (a_load),
    .Shift_En (a_shift),
    .Shift_In (q_msb),
    .Load_Val (a_d),
    .Data_Out (Remainder),
    .Shift_Out(a_msb)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (Run) begin
            if (Divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              m_q     <= divisor_mag;
              count_q <= '0;
`ifdef SIGNED_DIV_EN
              q_neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
              r_neg_q <= Dividend[WIDTH-1];
`endif
            end
          end
        end
        CALC: begin
          count_q <= count_q + 1'b1;
          if (last_iter) begin
`ifdef SIGNED_DIV_EN
            state_q <= FIX;
`else
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end
        end
        FIX: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          // Holding Run keeps the result; only a released Run re-arms the divider.
          if (!Run) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_shift_divider.sv
// Scoreboard bench for shift_divider: expectations are queued at start and popped when Done rises.
// Build with SIGNED_DIV_EN defined to exercise the signed variant.
module tb_shift_divider;

  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int CALC_LAT = W + 1;
`else
  localparam int CALC_LAT = W;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset, Run;
  logic [W-1:0] Dividend, Divisor;
  logic         Busy, Done, Div_By_Zero;
  logic [W-1:0] Quotient, Remainder;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  shift_divider #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Run        (Run),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .Busy       (Busy),
    .Done       (Done),
    .Div_By_Zero(Div_By_Zero),
    .Quotient   (Quotient),
    .Remainder  (Remainder)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
    return e;
  endfunction

  // Reference model: long division on magnitudes, then sign correction.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb, uq, ur;
    logic         sa, sb;
    if (b == '0) return mk('1, a, 1'b1, 0);
`ifdef SIGNED_DIV_EN
    sa = a[W-1];
    sb = b[W-1];
`else
    sa = 1'b0;
    sb = 1'b0;
`endif
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    uq = ma / mb;
    ur = ma % mb;
    return mk((sa ^ sb) ? -uq : uq, sa ? -ur : ur, 1'b0, CALC_LAT);
  endfunction

  // Drives one division, checks Busy every calc cycle, latency, result, hold and release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int hold);
    exp_t got;
    int   k;
    sb_q.push_back(e);
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    @(posedge Clk); #1;
    Dividend = W'($urandom);
    Divisor  = W'($urandom);
    k = 0;
    while (Done !== 1'b1 && k < 40) begin
      checks++;
      if (Busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_calc %0d/%0d edge=%0d got=%b exp=1", a, b, k, Busy);
      end
      if (k == 2) Run = 1'b0;
      if (k == 4) Run = 1'b1;
      @(posedge Clk); #1;
      k++;
    end
    checks++;
    if (k !== e.lat) begin
      errors++;
      $display("FAIL latency %0d/%0d got=%0d exp=%0d", a, b, k, e.lat);
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty %0d/%0d", a, b);
    end else begin
      got = sb_q.pop_front();
      checks++;
      if ({Quotient, Remainder, Div_By_Zero, Busy} !== {got.q, got.r, got.dbz, 1'b0}) begin
        errors++;
        $display("FAIL result %0d/%0d got q=%h r=%h dbz=%b busy=%b exp q=%h r=%h dbz=%b busy=0",
                 a, b, Quotient, Remainder, Div_By_Zero, Busy, got.q, got.r, got.dbz);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      checks++;
      if ({Done, Busy, Quotient, Remainder} !== {1'b1, 1'b0, e.q, e.r}) begin
        errors++;
        $display("FAIL hold cycle=%0d got done=%b busy=%b q=%h r=%h exp done=1 busy=0 q=%h r=%h",
                 i, Done, Busy, Quotient, Remainder, e.q, e.r);
      end
    end
    @(negedge Clk);
    Run = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({Done, Div_By_Zero, Busy, Quotient, Remainder} !== {3'b000, e.q, e.r}) begin
      errors++;
      $display("FAIL release got done=%b dbz=%b busy=%b q=%h r=%h exp done=0 dbz=0 busy=0 q=%h r=%h",
               Done, Div_By_Zero, Busy, Quotient, Remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({Busy, Done, Div_By_Zero, Quotient, Remainder} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b dbz=%b q=%h r=%h exp all 0",
               Busy, Done, Div_By_Zero, Quotient, Remainder);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_spec_vectors();
`ifndef SIGNED_DIV_EN
    run_op(8'd100, 8'd7,   mk(8'd14,  8'd2,  1'b0, W), 0);
    run_op(8'd255, 8'd1,   mk(8'd255, 8'd0,  1'b0, W), 0);
    run_op(8'd3,   8'd200, mk(8'd0,   8'd3,  1'b0, W), 0);
    run_op(8'd200, 8'd128, mk(8'd1,   8'd72, 1'b0, W), 0);
    run_op(8'd0,   8'd9,   mk(8'd0,   8'd0,  1'b0, W), 0);
`else
    run_op(8'h9C, 8'd7,  mk(8'hF2, 8'hFE, 1'b0, W + 1), 0);
    run_op(8'd100, 8'hF9, mk(8'hF2, 8'd2, 1'b0, W + 1), 0);
    run_op(8'h80, 8'hFF, mk(8'h80, 8'd0,  1'b0, W + 1), 0);
`endif
  endtask

  task automatic test_div_by_zero();
    run_op(8'd5, 8'd0, mk(8'hFF, 8'd5, 1'b1, 0), 0);
  endtask

  task automatic test_run_held();
    run_op(8'd50, 8'd6, model(8'd50, 8'd6), 30);
  endtask

  task automatic test_reset_mid_calc();
    @(negedge Clk);
    Dividend = 8'd100; Divisor = 8'd7; Run = 1'b1;
    @(posedge Clk); #1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    Run   = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({Busy, Done, Div_By_Zero, Quotient, Remainder} !== '0) begin
      errors++;
      $display("FAIL reset_mid_calc got busy=%b done=%b dbz=%b q=%h r=%h exp all 0",
               Busy, Done, Div_By_Zero, Quotient, Remainder);
    end
    @(negedge Clk);
    Reset = 1'b0;
    run_op(8'd9, 8'd4, mk(8'd2, 8'd1, 1'b0, CALC_LAT), 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom);
      b = W'($urandom_range(1, 255));
      run_op(a, b, model(a, b), 0);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_div_by_zero();
    test_run_held();
    test_reset_mid_calc();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
